// File: rtl/instr_register_pkg.sv
// instr_register_pkg: shared types for the instruction register and its scheduler
package instr_register_pkg;
  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic [4:0] address_t;
  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;
  typedef enum logic {S_INIT, S_RUN} sched_state_t;
  localparam int IREG_DEPTH = 32;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; last_grant names the previous winner
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic enable,
  input  logic last_grant,
  output logic gnt0,
  output logic gnt1
);
  assign gnt0 = enable && valid0 && (!valid1 || last_grant);
  assign gnt1 = enable && valid1 && (!valid0 || !last_grant);
endmodule

// File: rtl/instr_reg_scheduler.sv
// instr_reg_scheduler: arbitrates two producers into the instruction register and runs it as a FIFO
module instr_reg_scheduler
  import instr_register_pkg::*;
#(
  parameter int INIT_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          req0_valid,
  input  opcode_t                       req0_opcode,
  input  operand_t                      req0_operand_a,
  input  operand_t                      req0_operand_b,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  opcode_t                       req1_opcode,
  input  operand_t                      req1_operand_a,
  input  operand_t                      req1_operand_b,
  output logic                          req1_ready,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output instruction_t                  rd_instr,
  output logic                          load_en,
  output logic                          reg_reset_n,
  output opcode_t                       opcode,
  output operand_t                      operand_a,
  output operand_t                      operand_b,
  output address_t                      write_pointer,
  output address_t                      read_pointer,
  input  instruction_t                  instruction_word,
  output logic [$clog2(IREG_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);
  localparam int CW = $clog2(INIT_CYCLES) + 1;
  localparam int NW = $clog2(IREG_DEPTH) + 1;
  sched_state_t r_state, w_next;
  logic [CW-1:0] r_init_cnt;
  logic [NW-1:0] r_count;
  address_t r_wp, r_rp;
  logic r_last_grant;
  logic w_run, w_gnt0, w_gnt1, w_push, w_pop, w_init_done;
  assign w_run       = r_state == S_RUN;
  assign w_init_done = r_init_cnt == CW'(INIT_CYCLES - 1);
  assign full        = r_count == NW'(IREG_DEPTH);
  assign empty       = r_count == '0;
  // flush blocks both ports so no transfer is half-done when the queue is cleared
  assign rd_valid    = w_run && !empty && !flush;
  assign w_pop       = rd_valid && rd_ready;
  assign w_push      = w_gnt0 || w_gnt1;
  assign count         = r_count;
  assign write_pointer = r_wp;
  assign read_pointer  = r_rp;
  assign rd_instr      = instruction_word;
  rr_arb2 u_arb (
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .enable    (w_run && !full && !flush),
    .last_grant(r_last_grant),
    .gnt0      (w_gnt0),
    .gnt1      (w_gnt1)
  );
  always_comb begin
    w_next      = w_run ? (flush ? S_INIT : S_RUN) : ((w_init_done && !flush) ? S_RUN : S_INIT);
    req0_ready  = w_gnt0;
    req1_ready  = w_gnt1;
    load_en     = w_push;
    reg_reset_n = w_run;
    opcode      = w_gnt0 ? req0_opcode : (w_gnt1 ? req1_opcode : ZERO);
    operand_a   = w_gnt0 ? req0_operand_a : (w_gnt1 ? req1_operand_a : '0);
    operand_b   = w_gnt0 ? req0_operand_b : (w_gnt1 ? req1_operand_b : '0);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_INIT;
      r_init_cnt   <= '0;
      r_wp         <= '0;
      r_rp         <= '0;
      r_count      <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_init_cnt <= (w_run || flush || w_init_done) ? '0 : r_init_cnt + 1'b1;
      if (w_push) r_last_grant <= w_gnt1;
      if (!w_run || flush) begin
        r_wp    <= '0;
        r_rp    <= '0;
        r_count <= '0;
      end else begin
        r_wp    <= r_wp + address_t'(w_push);
        r_rp    <= r_rp + address_t'(w_pop);
        r_count <= r_count + NW'(w_push) - NW'(w_pop);
      end
    end
  end
endmodule
